// File: rtl/dc_download_regs.sv
`default_nettype none
// ============================================================================
// Module   : dc_download_regs
// Brief    : Data-cache download flit collector. Assembles one head-to-tail
//            message from the IN-node arbiter stream into a flat register,
//            holds it for the data cache until acknowledged, and reports
//            idle/busy/rdy back to the arbiter for flow control.
// Revision : 1.0 - initial release
// ============================================================================
module dc_download_regs #(
    parameter int MAX_FLITS = 11,
    parameter int CNT_W     = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    v_dc,
    input  logic [15:0]             flit_dc,
    input  logic [1:0]              ctrl_dc,
    input  logic                    dc_done_access,
    output logic [1:0]              dc_download_state,
    output logic                    v_dc_download,
    output logic [16*MAX_FLITS-1:0] dc_download_flits,
    output logic [CNT_W-1:0]        dc_flit_cnt
);

    localparam logic [1:0]       c_CTRL_HEAD = 2'b01;
    localparam logic [1:0]       c_CTRL_BODY = 2'b10;
    localparam logic [1:0]       c_CTRL_TAIL = 2'b11;
    localparam logic [CNT_W-1:0] c_CNT_MAX   = CNT_W'(MAX_FLITS);
    localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_RDY  = 2'b10
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_load_head;   // clear slots, store head in slot 0
    logic             w_store_flit;  // store body/tail at slot r_cnt
    logic [15:0]      r_slot [MAX_FLITS];
    logic [CNT_W-1:0] r_cnt;

    // Next-state and datapath-control decode; depends only on current state and inputs
    always_comb begin
        w_state_nxt  = r_state;
        w_load_head  = 1'b0;
        w_store_flit = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (v_dc && ctrl_dc == c_CTRL_HEAD) begin
                    w_load_head = 1'b1;
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (v_dc) begin
                    case (ctrl_dc)
                        // A second head resynchronises onto the new message
                        c_CTRL_HEAD: w_load_head = 1'b1;
                        c_CTRL_BODY: w_store_flit = (r_cnt < c_CNT_MAX);
                        c_CTRL_TAIL: begin
                            // Tail completes the message even when its payload is dropped
                            w_store_flit = (r_cnt < c_CNT_MAX);
                            w_state_nxt  = ST_RDY;
                        end
                        default: ;
                    endcase
                end
            end
            ST_RDY: begin
                if (dc_done_access) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Slot storage and flit counter; contents persist through rdy->idle until the next head
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < MAX_FLITS; k++) begin
                r_slot[k] <= 16'h0000;
            end
            r_cnt <= '0;
        end else if (w_load_head) begin
            for (int k = 1; k < MAX_FLITS; k++) begin
                r_slot[k] <= 16'h0000;
            end
            r_slot[0] <= flit_dc;
            r_cnt     <= c_CNT_ONE;
        end else if (w_store_flit) begin
            for (int k = 0; k < MAX_FLITS; k++) begin
                if (r_cnt == CNT_W'(k)) begin
                    r_slot[k] <= flit_dc;
                end
            end
            r_cnt <= r_cnt + c_CNT_ONE;
        end
    end

    // Flatten slots so slot 0 (the head) lands in the MSBs
    generate
        for (genvar k = 0; k < MAX_FLITS; k++) begin : g_pack
            assign dc_download_flits[16*(MAX_FLITS-k)-1 -: 16] = r_slot[k];
        end
    endgenerate

    assign dc_download_state = r_state;
    assign v_dc_download     = (r_state == ST_RDY);
    assign dc_flit_cnt       = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_dc_download_regs.sv
`default_nettype none
// ============================================================================
// Module   : tb_dc_download_regs
// Brief    : Directed self-checking bench for dc_download_regs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dc_download_regs;

    localparam int MAX = 11;
    localparam int CW  = 4;

    logic              clk;
    logic              rst;
    logic              v_dc;
    logic [15:0]       flit_dc;
    logic [1:0]        ctrl_dc;
    logic              dc_done_access;
    logic [1:0]        dc_download_state;
    logic              v_dc_download;
    logic [16*MAX-1:0] dc_download_flits;
    logic [CW-1:0]     dc_flit_cnt;

    int n_checks;
    int n_fail;

    dc_download_regs #(.MAX_FLITS(MAX), .CNT_W(CW)) dut (
        .clk               (clk),
        .rst               (rst),
        .v_dc              (v_dc),
        .flit_dc           (flit_dc),
        .ctrl_dc           (ctrl_dc),
        .dc_done_access    (dc_done_access),
        .dc_download_state (dc_download_state),
        .v_dc_download     (v_dc_download),
        .dc_download_flits (dc_download_flits),
        .dc_flit_cnt       (dc_flit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Slot k of the flat message vector (slot 0 in the MSBs)
    function automatic logic [15:0] slot(input int k);
        logic [16*MAX-1:0] t;
        t = dc_download_flits >> (16*(MAX-1-k));
        return t[15:0];
    endfunction

    // One cycle of stimulus: inputs applied at a falling edge, held across
    // the rising edge, then returned to quiet at the next falling edge.
    task automatic drive(input logic v, input logic [1:0] c, input logic [15:0] f,
                         input logic done);
        v_dc = v; ctrl_dc = c; flit_dc = f; dc_done_access = done;
        @(negedge clk);
        v_dc = 1'b0; ctrl_dc = 2'b00; flit_dc = 16'h0000; dc_done_access = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (dc_download_state !== 2'b00) begin n_fail++; $display("FAIL reset_state: got %b want 00", dc_download_state); end
        n_checks++; if (v_dc_download !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", v_dc_download); end
        n_checks++; if (dc_download_flits !== '0) begin n_fail++; $display("FAIL reset_flits: got %h want 0", dc_download_flits); end
        n_checks++; if (dc_flit_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", dc_flit_cnt); end
        drive(1'b1, 2'b10, 16'h1234, 1'b0);
        n_checks++; if (dc_download_state !== 2'b00) begin n_fail++; $display("FAIL idle_body_state: got %b want 00", dc_download_state); end
        n_checks++; if (dc_flit_cnt !== 4'd0) begin n_fail++; $display("FAIL idle_body_cnt: got %0d want 0", dc_flit_cnt); end
        n_checks++; if (dc_download_flits !== '0) begin n_fail++; $display("FAIL idle_body_flits: got %h want 0", dc_download_flits); end
    endtask

    task automatic test_long_message();
        drive(1'b1, 2'b01, 16'h0A80, 1'b0);
        n_checks++; if (dc_download_state !== 2'b01) begin n_fail++; $display("FAIL long_head_state: got %b want 01", dc_download_state); end
        n_checks++; if (dc_flit_cnt !== 4'd1) begin n_fail++; $display("FAIL long_head_cnt: got %0d want 1", dc_flit_cnt); end
        for (int i = 1; i <= 9; i++) drive(1'b1, 2'b10, 16'(i), 1'b0);
        n_checks++; if (v_dc_download !== 1'b0) begin n_fail++; $display("FAIL long_pre_tail_valid: got %b want 0", v_dc_download); end
        drive(1'b1, 2'b11, 16'h000A, 1'b0);
        n_checks++; if (dc_download_state !== 2'b10) begin n_fail++; $display("FAIL long_state: got %b want 10", dc_download_state); end
        n_checks++; if (v_dc_download !== 1'b1) begin n_fail++; $display("FAIL long_valid: got %b want 1", v_dc_download); end
        n_checks++; if (dc_flit_cnt !== 4'd11) begin n_fail++; $display("FAIL long_cnt: got %0d want 11", dc_flit_cnt); end
        n_checks++; if (dc_download_flits[175:160] !== 16'h0A80) begin n_fail++; $display("FAIL long_msb: got %h want 0a80", dc_download_flits[175:160]); end
        n_checks++; if (dc_download_flits[15:0] !== 16'h000A) begin n_fail++; $display("FAIL long_lsb: got %h want 000a", dc_download_flits[15:0]); end
        for (int k = 1; k <= 9; k++) begin
            n_checks++; if (slot(k) !== 16'(k)) begin n_fail++; $display("FAIL long_slot%0d: got %h want %h", k, slot(k), 16'(k)); end
        end
        drive(1'b0, 2'b00, 16'h0000, 1'b1);
        n_checks++; if (dc_download_state !== 2'b00) begin n_fail++; $display("FAIL long_done_state: got %b want 00", dc_download_state); end
        n_checks++; if (v_dc_download !== 1'b0) begin n_fail++; $display("FAIL long_done_valid: got %b want 0", v_dc_download); end
        n_checks++; if (dc_flit_cnt !== 4'd11) begin n_fail++; $display("FAIL long_done_cnt_kept: got %0d want 11", dc_flit_cnt); end
        n_checks++; if (slot(0) !== 16'h0A80) begin n_fail++; $display("FAIL long_done_flits_kept: got %h want 0a80", slot(0)); end
    endtask

    task automatic test_short_message();
        drive(1'b1, 2'b01, 16'h2000, 1'b0);
        drive(1'b1, 2'b11, 16'hBEEF, 1'b0);
        n_checks++; if (dc_download_state !== 2'b10) begin n_fail++; $display("FAIL short_state: got %b want 10", dc_download_state); end
        n_checks++; if (dc_flit_cnt !== 4'd2) begin n_fail++; $display("FAIL short_cnt: got %0d want 2", dc_flit_cnt); end
        n_checks++; if (slot(0) !== 16'h2000) begin n_fail++; $display("FAIL short_slot0: got %h want 2000", slot(0)); end
        n_checks++; if (slot(1) !== 16'hBEEF) begin n_fail++; $display("FAIL short_slot1: got %h want beef", slot(1)); end
        for (int k = 2; k < MAX; k++) begin
            n_checks++; if (slot(k) !== 16'h0000) begin n_fail++; $display("FAIL short_slot%0d_cleared: got %h want 0000", k, slot(k)); end
        end
        drive(1'b0, 2'b00, 16'h0000, 1'b1);
        n_checks++; if (dc_download_state !== 2'b00) begin n_fail++; $display("FAIL short_done_state: got %b want 00", dc_download_state); end
    endtask

    task automatic test_overflow();
        drive(1'b1, 2'b01, 16'h3000, 1'b0);
        for (int i = 1; i <= 12; i++) drive(1'b1, 2'b10, 16'h3000 + 16'(i), 1'b0);
        n_checks++; if (dc_flit_cnt !== 4'd11) begin n_fail++; $display("FAIL ovf_cnt_sat: got %0d want 11", dc_flit_cnt); end
        n_checks++; if (dc_download_state !== 2'b01) begin n_fail++; $display("FAIL ovf_pre_tail_state: got %b want 01", dc_download_state); end
        drive(1'b1, 2'b11, 16'h30FF, 1'b0);
        n_checks++; if (dc_download_state !== 2'b10) begin n_fail++; $display("FAIL ovf_state: got %b want 10", dc_download_state); end
        n_checks++; if (dc_flit_cnt !== 4'd11) begin n_fail++; $display("FAIL ovf_cnt: got %0d want 11", dc_flit_cnt); end
        for (int k = 0; k < MAX; k++) begin
            n_checks++; if (slot(k) !== 16'h3000 + 16'(k)) begin n_fail++; $display("FAIL ovf_slot%0d: got %h want %h", k, slot(k), 16'h3000 + 16'(k)); end
        end
    endtask

    // Entered with the overflow message held in rdy
    task automatic test_stray_traffic();
        drive(1'b1, 2'b01, 16'h4444, 1'b0);
        drive(1'b1, 2'b10, 16'h5555, 1'b0);
        drive(1'b1, 2'b11, 16'h6666, 1'b0);
        drive(1'b1, 2'b00, 16'h7777, 1'b0);
        n_checks++; if (dc_download_state !== 2'b10) begin n_fail++; $display("FAIL stray_state: got %b want 10", dc_download_state); end
        n_checks++; if (dc_flit_cnt !== 4'd11) begin n_fail++; $display("FAIL stray_cnt: got %0d want 11", dc_flit_cnt); end
        n_checks++; if (slot(0) !== 16'h3000) begin n_fail++; $display("FAIL stray_slot0: got %h want 3000", slot(0)); end
        n_checks++; if (slot(10) !== 16'h300A) begin n_fail++; $display("FAIL stray_slot10: got %h want 300a", slot(10)); end
        drive(1'b0, 2'b00, 16'h0000, 1'b1);
        drive(1'b1, 2'b01, 16'h6000, 1'b0);
        drive(1'b0, 2'b00, 16'h0000, 1'b1);
        n_checks++; if (dc_download_state !== 2'b01) begin n_fail++; $display("FAIL busy_done_state: got %b want 01", dc_download_state); end
        n_checks++; if (dc_flit_cnt !== 4'd1) begin n_fail++; $display("FAIL busy_done_cnt: got %0d want 1", dc_flit_cnt); end
        n_checks++; if (slot(1) !== 16'h0000) begin n_fail++; $display("FAIL head_clears_slot1: got %h want 0000", slot(1)); end
    endtask

    // Entered busy with one flit stored
    task automatic test_reset_resync();
        drive(1'b1, 2'b10, 16'h6001, 1'b0);
        drive(1'b1, 2'b10, 16'h6002, 1'b0);
        rst = 1'b1;
        v_dc = 1'b1; ctrl_dc = 2'b11; flit_dc = 16'h6003;
        @(negedge clk);
        rst = 1'b0; v_dc = 1'b0; ctrl_dc = 2'b00; flit_dc = 16'h0000;
        n_checks++; if (dc_download_state !== 2'b00) begin n_fail++; $display("FAIL midrst_state: got %b want 00", dc_download_state); end
        n_checks++; if (dc_flit_cnt !== 4'd0) begin n_fail++; $display("FAIL midrst_cnt: got %0d want 0", dc_flit_cnt); end
        n_checks++; if (dc_download_flits !== '0) begin n_fail++; $display("FAIL midrst_flits: got %h want 0", dc_download_flits); end
        drive(1'b1, 2'b01, 16'h7000, 1'b0);
        drive(1'b1, 2'b10, 16'h7001, 1'b0);
        drive(1'b1, 2'b10, 16'h7002, 1'b0);
        drive(1'b1, 2'b01, 16'h7100, 1'b0);
        n_checks++; if (dc_download_state !== 2'b01) begin n_fail++; $display("FAIL resync_state: got %b want 01", dc_download_state); end
        n_checks++; if (dc_flit_cnt !== 4'd1) begin n_fail++; $display("FAIL resync_cnt: got %0d want 1", dc_flit_cnt); end
        n_checks++; if (slot(0) !== 16'h7100) begin n_fail++; $display("FAIL resync_slot0: got %h want 7100", slot(0)); end
        n_checks++; if (slot(1) !== 16'h0000 || slot(2) !== 16'h0000) begin n_fail++; $display("FAIL resync_cleared: got %h/%h want 0000/0000", slot(1), slot(2)); end
        drive(1'b1, 2'b11, 16'h71FF, 1'b0);
        n_checks++; if (dc_flit_cnt !== 4'd2 || slot(1) !== 16'h71FF) begin n_fail++; $display("FAIL resync_tail: got cnt %0d slot1 %h want 2/71ff", dc_flit_cnt, slot(1)); end
    endtask

    // Entered in rdy: done pulse followed immediately by the next head
    task automatic test_back_to_back();
        drive(1'b0, 2'b00, 16'h0000, 1'b1);
        drive(1'b1, 2'b01, 16'h8000, 1'b0);
        n_checks++; if (dc_download_state !== 2'b01) begin n_fail++; $display("FAIL b2b_state: got %b want 01", dc_download_state); end
        n_checks++; if (dc_flit_cnt !== 4'd1) begin n_fail++; $display("FAIL b2b_cnt: got %0d want 1", dc_flit_cnt); end
        n_checks++; if (slot(0) !== 16'h8000) begin n_fail++; $display("FAIL b2b_slot0: got %h want 8000", slot(0)); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1; v_dc = 1'b0; flit_dc = 16'h0000; ctrl_dc = 2'b00; dc_done_access = 1'b0;
        @(negedge clk);
        test_reset();
        test_long_message();
        test_short_message();
        test_overflow();
        test_stray_traffic();
        test_reset_resync();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
